debounce_sync: RTL and testbench

Input conditioning stage that sits directly upstream of the rising-edge detector. It takes a raw, asynchronous level such as a push-button or external strobe, synchronizes it into the `clk` domain, and filters out bounce and glitches. It then presents a clean, metastability-free level on `out`, which the edge detector consumes. It also reports whether a transition is being qualified and counts rejected glitches for debug.

---
 rtl/debounce_pkg.sv | 20 ++
 rtl/sync_nff.sv | 24 ++
 rtl/debounce_sync.sv | 105 ++++++++++
 tb/tb_debounce_sync.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and default constants for the debounce/synchronizer stage.
package debounce_pkg;

  // Debounce FSM states. IDLE_* hold a settled level; WAIT_* qualify a change.
  typedef enum logic [1:0] {
    IDLE_LO = 2'b00,
    WAIT_HI = 2'b01,
    IDLE_HI = 2'b10,
    WAIT_LO = 2'b11
  } db_state_t;

  localparam int DB_SYNC_STAGES   = 2;
  localparam int DB_STABLE_CYCLES = 4;

  // True for the two qualifying states.
  function automatic logic db_is_wait(input db_state_t st);
    return (st == WAIT_HI) || (st == WAIT_LO);
  endfunction

endpackage : debounce_pkg

// File: rtl/sync_nff.sv
// Generic N-flop level synchronizer with asynchronous active-low reset to 0.
module sync_nff #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [N-1:0] sync_q;

  // Shift the raw level through N flops; only the last one is safe to use.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[N-2:0], d_i};
    end
  end

  assign q_o = sync_q[N-1];

endmodule : sync_nff

// File: rtl/debounce_sync.sv
// Synchronizes a raw asynchronous level and debounces it: the output only
// follows a new level after it has persisted for STABLE_CYCLES sampling edges.
// Aborted qualifications are counted in a saturating glitch counter.
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = DB_SYNC_STAGES,
  parameter int STABLE_CYCLES = DB_STABLE_CYCLES,
  parameter int GLITCH_W      = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in,
  output logic                out,
  output logic                busy,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]       CNT_LAST   = CW'(STABLE_CYCLES - 1);
  localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

  logic                s;
  db_state_t           state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                out_q, out_d;
  logic                busy_q, busy_d;
  logic [GLITCH_W-1:0] glitch_q, glitch_d;

  // The FSM only ever looks at the synchronized copy of the input.
  sync_nff #(.N(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (reset),
    .d_i   (in),
    .q_o   (s)
  );

  // Next-state logic: qualify level changes, reject short excursions.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    glitch_d = glitch_q;
    unique case (state_q)
      IDLE_LO, IDLE_HI: begin
        if (s != out_q) begin
          if (STABLE_CYCLES == 1) begin
            // No qualification window: follow the synchronized level directly.
            out_d   = ~out_q;
            state_d = out_q ? IDLE_LO : IDLE_HI;
          end else begin
            state_d = out_q ? WAIT_LO : WAIT_HI;
            cnt_d   = CW'(1);
          end
        end
      end
      WAIT_HI, WAIT_LO: begin
        if (s != out_q) begin
          if (cnt_q == CNT_LAST) begin
            out_d   = ~out_q;
            state_d = out_q ? IDLE_LO : IDLE_HI;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          // Level fell back before qualifying: one rejected excursion.
          state_d = out_q ? IDLE_HI : IDLE_LO;
          cnt_d   = '0;
          if (glitch_q != GLITCH_MAX) begin
            glitch_d = glitch_q + GLITCH_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE_LO;
        cnt_d   = '0;
        out_d   = 1'b0;
      end
    endcase
    busy_d = db_is_wait(state_d);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE_LO;
      cnt_q    <= '0;
      out_q    <= 1'b0;
      busy_q   <= 1'b0;
      glitch_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      busy_q   <= busy_d;
      glitch_q <= glitch_d;
    end
  end

  assign out        = out_q;
  assign busy       = busy_q;
  assign glitch_cnt = glitch_q;

endmodule : debounce_sync

// File: tb/tb_debounce_sync.sv
// Self-checking bench for debounce_sync: three parameterisations driven by the
// same input, each compared every cycle against a history-based model.
module tb_debounce_sync;

  logic       clk;
  logic       reset;
  logic       din;
  logic       out0, busy0, out1, busy1, out2, busy2;
  logic [7:0] gl0;
  logic [1:0] gl1;
  logic [7:0] gl2;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Default configuration.
  debounce_sync #(.SYNC_STAGES(2), .STABLE_CYCLES(4), .GLITCH_W(8)) dut0 (
    .clk(clk), .reset(reset), .in(din), .out(out0), .busy(busy0), .glitch_cnt(gl0));
  // Deeper synchronizer, shorter window, tiny glitch counter.
  debounce_sync #(.SYNC_STAGES(3), .STABLE_CYCLES(3), .GLITCH_W(2)) dut1 (
    .clk(clk), .reset(reset), .in(din), .out(out1), .busy(busy1), .glitch_cnt(gl1));
  // No qualification window.
  debounce_sync #(.SYNC_STAGES(2), .STABLE_CYCLES(1), .GLITCH_W(8)) dut2 (
    .clk(clk), .reset(reset), .in(din), .out(out2), .busy(busy2), .glitch_cnt(gl2));

  logic d_out[3];
  logic d_busy[3];
  int   d_gl[3];
  assign d_out[0] = out0;  assign d_busy[0] = busy0;  assign d_gl[0] = int'(gl0);
  assign d_out[1] = out1;  assign d_busy[1] = busy1;  assign d_gl[1] = int'(gl1);
  assign d_out[2] = out2;  assign d_busy[2] = busy2;  assign d_gl[2] = int'(gl2);

  function automatic int p_sync(input int i);
    return (i == 1) ? 3 : 2;
  endfunction
  function automatic int p_stab(input int i);
    return (i == 0) ? 4 : ((i == 1) ? 3 : 1);
  endfunction
  function automatic int p_gmax(input int i);
    return (i == 1) ? 3 : 255;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: keeps the raw samples of in and the history of the
  // synchronized level seen at each edge. The output flips once the last
  // STABLE samples all disagree with it; a glitch is a mismatching sample
  // immediately followed by a matching one.
  logic [7:0] m_sync[3];
  logic [7:0] m_hist[3];
  logic       m_out[3];
  logic       m_busy[3];
  int         m_gl[3];

  always @(posedge clk or negedge reset) begin : model
    logic       s_now, s_prev, o_new, all_diff;
    logic [7:0] h_new, mask;
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        m_sync[i] <= '0;
        m_hist[i] <= '0;
        m_out[i]  <= 1'b0;
        m_busy[i] <= 1'b0;
        m_gl[i]   <= 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        s_now    = m_sync[i][p_sync(i)-1];
        s_prev   = m_hist[i][0];
        h_new    = {m_hist[i][6:0], s_now};
        mask     = 8'((1 << p_stab(i)) - 1);
        all_diff = m_out[i] ? ((h_new & mask) == 8'd0) : ((h_new & mask) == mask);
        o_new    = all_diff ? ~m_out[i] : m_out[i];
        if (s_now == m_out[i] && s_prev != m_out[i] && m_gl[i] < p_gmax(i))
          m_gl[i] <= m_gl[i] + 1;
        m_sync[i] <= {m_sync[i][6:0], din};
        m_hist[i] <= h_new;
        m_out[i]  <= o_new;
        m_busy[i] <= (s_now != o_new);
      end
    end
  end

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("out%0d", i),    int'(d_out[i]),  int'(m_out[i]));
        chk($sformatf("busy%0d", i),   int'(d_busy[i]), int'(m_busy[i]));
        chk($sformatf("glitch%0d", i), d_gl[i],         m_gl[i]);
      end
    end
  end

  task automatic post_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit saw_busy;
    int v, len;
    reset = 1'b1;
    din   = 1'b0;
    #2 reset = 1'b0;
    #1;
    // Asynchronous reset takes effect with no clock edge.
    chk("rst_out0", int'(out0), 0);
    chk("rst_busy0", int'(busy0), 0);
    chk("rst_glitch0", int'(gl0), 0);
    chk("rst_glitch1", int'(gl1), 0);
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // Rise: out at E5 (default), E2 (STABLE=1); busy at E2..E4.
    din = 1'b1;
    for (int k = 0; k < 10; k++) begin
      post_edge();
      chk($sformatf("rise_out0_E%0d", k), int'(out0), (k >= 5) ? 1 : 0);
      chk($sformatf("rise_busy0_E%0d", k), int'(busy0), (k >= 2 && k <= 4) ? 1 : 0);
      chk($sformatf("rise_out2_E%0d", k), int'(out2), (k >= 2) ? 1 : 0);
      chk($sformatf("rise_busy2_E%0d", k), int'(busy2), 0);
      if (k == 5) chk("model_rise_E5", int'(m_out[0]), 1);
    end
    chk("rise_glitch0", int'(gl0), 0);

    // Two-cycle low pulse while out=1.
    @(negedge clk) din = 1'b0;
    @(negedge clk);
    @(negedge clk) din = 1'b1;
    saw_busy = 0;
    for (int k = 0; k < 10; k++) begin
      post_edge();
      if (busy0) saw_busy = 1;
      chk($sformatf("pulse_out0_%0d", k), int'(out0), 1);
    end
    chk("pulse_busy0_seen", int'(saw_busy), 1);
    chk("pulse_glitch0", int'(gl0), 1);
    chk("pulse_glitch1", int'(gl1), 1);
    chk("pulse_glitch2", int'(gl2), 0);
    chk("model_pulse_glitch0", m_gl[0], 1);

    // Bounce: settle low, 12 toggles starting high, then settle high.
    @(negedge clk) din = 1'b0;
    repeat (10) @(negedge clk);
    chk("bounce_pre_out0", int'(out0), 0);
    for (int k = 0; k < 12; k++) begin
      din = (k % 2 == 0) ? 1'b1 : 1'b0;
      @(negedge clk);
      chk($sformatf("bounce_out0_%0d", k), int'(out0), 0);
    end
    din = 1'b1;
    repeat (12) @(negedge clk);
    chk("bounce_out0", int'(out0), 1);
    chk("bounce_glitch0", int'(gl0), 7);
    chk("bounce_glitch1_sat", int'(gl1), 3);
    chk("bounce_glitch2", int'(gl2), 0);
    chk("model_bounce_glitch0", m_gl[0], 7);

    // Asynchronous reset in the middle of WAIT_HI.
    din = 1'b0;
    repeat (10) @(negedge clk);
    din = 1'b1;
    post_edge();
    post_edge();
    post_edge();
    #2;
    chk("abort_busy0_pre", int'(busy0), 1);
    reset = 1'b0;
    #1;
    chk("abort_out0", int'(out0), 0);
    chk("abort_busy0", int'(busy0), 0);
    chk("abort_glitch0", int'(gl0), 0);
    @(negedge clk) reset = 1'b1;
    for (int k = 0; k < 7; k++) begin
      post_edge();
      chk($sformatf("relrise_out0_E%0d", k), int'(out0), (k >= 5) ? 1 : 0);
    end
    chk("relrise_glitch0", int'(gl0), 0);

    // Five isolated rejected glitches: 2-bit counter saturates.
    repeat (5) @(negedge clk);
    for (int g = 0; g < 5; g++) begin
      @(negedge clk) din = 1'b0;
      @(negedge clk) din = 1'b1;
      repeat (5) @(negedge clk);
    end
    chk("sat_glitch1", int'(gl1), 3);
    chk("sat_glitch0", int'(gl0), 5);
    chk("sat_out0", int'(out0), 1);

    // Random levels with random hold times and occasional async resets.
    for (int it = 0; it < 400; it++) begin
      v   = $urandom_range(0, 1);
      len = $urandom_range(1, 8);
      @(negedge clk) din = v[0];
      repeat (len - 1) @(negedge clk);
      if ($urandom_range(0, 49) == 0) begin
        @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        #1 reset = 1'b1;
      end
    end
    repeat (12) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_debounce_sync
